// File: rtl/dvsd_seqmul_pkg.sv
// Shared constants, FSM encoding and sizing helper for the dvsd_seqmul iterative multiplier.
package dvsd_seqmul_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } seqmul_state_e;

  // Down-counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dvsd_seqmul_signfix.sv
// Combinational sign handling: operand magnitudes and result sign on the way in,
// conditional two's-complement negate of the unsigned product on the way out.
module dvsd_seqmul_signfix
  import dvsd_seqmul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  output logic [WIDTH-1:0]   o_abs_a,
  output logic [WIDTH-1:0]   o_abs_b,
  output logic               o_neg,
  input  logic [2*WIDTH-1:0] i_mag,
  input  logic               i_neg,
  output logic [2*WIDTH-1:0] o_prod
);

  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = i_signed && i_a[WIDTH-1];
  assign w_b_neg = i_signed && i_b[WIDTH-1];

  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exactly right when read as unsigned.
  assign o_abs_a = w_a_neg ? -i_a : i_a;
  assign o_abs_b = w_b_neg ? -i_b : i_b;
  assign o_neg   = w_a_neg ^ w_b_neg;

  assign o_prod  = i_neg ? -i_mag : i_mag;

endmodule

// File: rtl/dvsd_seqmul.sv
// Iterative shift-add multiplier, one partial product per clock, valid/ready on both sides.
// Optional build macro DVSD_SEQMUL_ZERO_SKIP_EN shortens the run to one cycle for zero operands.
module dvsd_seqmul
  import dvsd_seqmul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_m
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  seqmul_state_e      r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_count;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_out_m;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_neg;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_accept;
  logic               w_skip;
  logic               w_last;

  dvsd_seqmul_signfix #(
    .WIDTH (WIDTH)
  ) u_signfix (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_signed (in_signed),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .o_neg    (w_neg),
    .i_mag    (w_acc_next),
    .i_neg    (r_neg),
    .o_prod   (w_prod)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_m     = r_out_m;
  assign w_accept  = in_valid && in_ready;

`ifdef DVSD_SEQMUL_ZERO_SKIP_EN
  assign w_skip = (w_abs_a == '0) || (w_abs_b == '0);
`else
  assign w_skip = 1'b0;
`endif

  // Multiplier magnitude lives in the low half of acc; its LSB selects each partial product.
  assign w_addend   = r_acc[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_last     = (r_count == CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_out_m <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand <= w_abs_a;
            r_neg   <= w_neg;
            // A skipped zero runs one pass with an empty multiplier, yielding 0.
            r_acc   <= w_skip ? '0 : {{WIDTH{1'b0}}, w_abs_b};
            r_count <= w_skip ? CNT_ONE : CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_acc   <= w_acc_next;
          r_count <= r_count - CNT_ONE;
          if (w_last) begin
            r_out_m <= w_prod;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvsd_seqmul.sv
// Self-checking bench for dvsd_seqmul: directed vector table, corner sequences, and
// randomized regression at WIDTH=8 and WIDTH=13 against an arithmetic reference model.
module tb_dvsd_seqmul;

`ifdef DVSD_SEQMUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] a, b;
  logic        s;
  logic        rdy;
  logic        iv8, iv13;
  logic        ir8, ir13, ov8, ov13;
  logic [15:0] m8;
  logic [25:0] m13;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dvsd_seqmul #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .in_a      (a[7:0]),
    .in_b      (b[7:0]),
    .in_signed (s),
    .out_valid (ov8),
    .out_ready (rdy),
    .out_m     (m8)
  );

  dvsd_seqmul #(.WIDTH(13)) u_dut13 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv13),
    .in_ready  (ir13),
    .in_a      (a),
    .in_b      (b),
    .in_signed (s),
    .out_valid (ov13),
    .out_ready (rdy),
    .out_m     (m13)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] m;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Product of the operands read as w-bit integers, wrapped to 2w bits.
  function automatic logic [63:0] ref_mul(input logic [12:0] x, input logic [12:0] y,
                                          input bit sg, input int w);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sg && x[w-1]) sx -= longint'(1) << w;
    if (sg && y[w-1]) sy -= longint'(1) << w;
    return 64'(sx * sy) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov13;
  endfunction

  function automatic logic get_ir(input int w);
    return (w == 8) ? ir8 : ir13;
  endfunction

  function automatic logic [25:0] get_m(input int w);
    return (w == 8) ? {10'd0, m8} : m13;
  endfunction

  task automatic set_iv(input int w, input logic v);
    if (w == 8) iv8 = v;
    else iv13 = v;
  endtask

  // One WIDTH=8 transaction: checks latency, busy in_ready, value, optional stall, release.
  task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic ts, input logic [15:0] exp, input int lat, input int hold);
    int n;
    bit rdy_low, stable;
    logic [15:0] held;
    rdy = 1'b0;
    a = {5'd0, ta};
    b = {5'd0, tb_};
    s = ts;
    iv8 = 1'b1;
    chk({nm, " ready_idle"}, 64'(ir8), 64'd1);
    tick();
    iv8 = 1'b0;
    a = ~a;
    b = ~b;
    s = ~s;
    n = 0;
    rdy_low = 1'b1;
    while (!ov8 && n < 64) begin
      if (ir8) rdy_low = 1'b0;
      tick();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " busy_ready"}, 64'(rdy_low), 64'd1);
    chk({nm, " value"}, 64'(m8), 64'(exp));
    held = m8;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      iv8 = k[0] ? 1'b0 : 1'b1;
      a = 13'($urandom);
      b = 13'($urandom);
      s = ~s;
      tick();
      if (m8 !== held || !ov8 || ir8) stable = 1'b0;
    end
    if (hold > 0) chk({nm, " stall_stable"}, 64'(stable), 64'd1);
    iv8 = 1'b0;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk({nm, " valid_drop"}, 64'(ov8), 64'd0);
    chk({nm, " ready_back"}, 64'(ir8), 64'd1);
  endtask

  task automatic rnd(input int w, input int ntx);
    logic [12:0] mask, ta, tb_;
    logic        ts;
    logic [63:0] exp;
    logic [25:0] cap;
    bit          bad, got, was;
    int          cyc;
    int          errs_before;
    mask = 13'((1 << w) - 1);
    errs_before = n_errors;
    for (int i = 0; i < ntx; i++) begin
      ta = 13'($urandom) & mask;
      tb_ = 13'($urandom) & mask;
      ts = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ta = '0;
      if ($urandom_range(0, 9) == 0) tb_ = '0;
      exp = ref_mul(ta, tb_, ts, w);
      a = ta;
      b = tb_;
      s = ts;
      set_iv(w, 1'b1);
      bad = !get_ir(w);
      tick();
      set_iv(w, 1'b0);
      got = 1'b0;
      cap = '0;
      cyc = 0;
      while (!got && cyc < 100) begin
        rdy = ($urandom_range(0, 2) != 0);
        set_iv(w, 1'($urandom_range(0, 1)));
        a = 13'($urandom);
        b = 13'($urandom);
        if (get_ir(w)) bad = 1'b1;
        was = get_ov(w) && rdy;
        cap = get_m(w);
        tick();
        cyc++;
        if (was) got = 1'b1;
      end
      set_iv(w, 1'b0);
      rdy = 1'b0;
      chk($sformatf("rnd%0d[%0d] delivered", w, i), 64'(got), 64'd1);
      chk($sformatf("rnd%0d[%0d] a=%0h b=%0h s=%0d", w, i, ta, tb_, ts), 64'(cap), exp);
      chk($sformatf("rnd%0d[%0d] handshake", w, i), 64'(bad), 64'd0);
      chk($sformatf("rnd%0d[%0d] no_dup", w, i), 64'({get_ov(w), get_ir(w)}), 64'b01);
      if (n_errors - errs_before > 20) begin
        $display("FAIL rnd%0d aborted after too many errors", w);
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, m: 16'hFE01, lat: 8};
    vecs[1] = '{a: 8'h80, b: 8'h80, s: 1'b1, m: 16'h4000, lat: 8};
    vecs[2] = '{a: 8'hFF, b: 8'h7F, s: 1'b1, m: 16'hFF81, lat: 8};
    vecs[3] = '{a: 8'h80, b: 8'h01, s: 1'b1, m: 16'hFF80, lat: 8};
    vecs[4] = '{a: 8'h7F, b: 8'h80, s: 1'b1, m: 16'hC080, lat: 8};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, s: 1'b1, m: 16'h0001, lat: 8};
    vecs[6] = '{a: 8'h80, b: 8'h80, s: 1'b0, m: 16'h4000, lat: 8};
    vecs[7] = '{a: 8'h00, b: 8'h5A, s: 1'b0, m: 16'h0000, lat: ZLAT};
    vecs[8] = '{a: 8'h37, b: 8'h00, s: 1'b1, m: 16'h0000, lat: ZLAT};

    reset = 1'b1;
    iv8 = 1'b0;
    iv13 = 1'b0;
    rdy = 1'b0;
    a = '0;
    b = '0;
    s = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset ready8", 64'(ir8), 64'd1);
    chk("reset valid8", 64'(ov8), 64'd0);
    chk("reset m8", 64'(m8), 64'd0);
    chk("reset ready13", 64'(ir13), 64'd1);
    chk("reset valid13", 64'(ov13), 64'd0);
    chk("reset m13", 64'(m13), 64'd0);

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].lat, 0);

    do_op("backpressure", 8'd12, 8'd10, 1'b0, 16'd120, 8, 5);

    // Reset three cycles into a run: no result may appear afterwards.
    begin
      bit quiet;
      a = 13'd200;
      b = 13'd100;
      s = 1'b0;
      iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset valid", 64'(ov8), 64'd0);
      chk("midreset ready", 64'(ir8), 64'd1);
      chk("midreset m", 64'(m8), 64'd0);
      quiet = 1'b1;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (ov8 || !ir8) quiet = 1'b0;
      end
      chk("midreset quiet", 64'(quiet), 64'd1);
      do_op("after_reset", 8'd3, 8'd5, 1'b0, 16'd15, 8, 0);
    end

    rnd(8, 2000);
    rnd(13, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
